// File: rtl/serial_sub.sv
// Digit-serial subtractor: operand1 - operand2 computed DIGIT bits per clock,
// LSB digit first, with start/busy/done handshake and borrow/overflow/zero flags.
module serial_sub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
    logic             bin;
    logic             a_msb, b_msb;
    logic             accept, last;
    logic [DIGIT:0]   dig;
    logic [WIDTH-1:0] diff_full;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        accept     = start && (state == IDLE || state == DONE);
        last       = (state == RUN) && (cnt == CW'(N - 1));
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One digit step; the extra top bit of dig is the digit borrow-out.
    always_comb begin
        dig       = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - (DIGIT + 1)'(bin);
        diff_full = (diff_sh >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            bin        <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow     <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept) begin
                a_sh  <= operand1;
                b_sh  <= operand2;
                a_msb <= operand1[WIDTH-1];
                b_msb <= operand2[WIDTH-1];
                bin   <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh    <= a_sh >> DIGIT;
                b_sh    <= b_sh >> DIGIT;
                diff_sh <= diff_full;
                bin     <= dig[DIGIT];
                cnt     <= cnt + 1'b1;
                // Results are published only on the final digit and then held.
                if (last) begin
                    difference <= diff_full;
                    borrow     <= dig[DIGIT];
                    overflow   <= (a_msb != b_msb) && (diff_full[WIDTH-1] != a_msb);
                    zero       <= (diff_full == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        busy, done, borrow, overflow, zero;
    logic [31:0] difference;

    int total = 0;
    int bad   = 0;

    logic [31:0] e_diff;
    logic        e_br, e_ov, e_z;

    serial_sub #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operand1  (operand1),
        .operand2  (operand2),
        .busy      (busy),
        .done      (done),
        .difference(difference),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction; overflow means the signed result
    // does not fit back into 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b);
        longint r;
        e_diff = a - b;
        e_br   = (a < b);
        r      = longint'($signed(a)) - longint'($signed(b));
        e_ov   = (r != longint'($signed(e_diff)));
        e_z    = (e_diff == 32'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
    endtask

    task automatic wait_done(output int bc);
        bit got;
        got = 1'b0;
        bc  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) bc++;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_diff"},     difference,      e_diff);
        check({tag, "_borrow"},   32'(borrow),     32'(e_br));
        check({tag, "_overflow"}, 32'(overflow),   32'(e_ov));
        check({tag, "_zero"},     32'(zero),       32'(e_z));
    endtask

    task automatic op_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int bc;
        model(a, b);
        start_op(a, b);
        wait_done(bc);
        check({tag, "_latency"}, 32'(bc), 32'd8);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_results(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bc;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", difference, 32'd0);
        check("rst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
        reset = 1'b0;

        op_and_check("sub10_3", 32'd10, 32'd3);
        op_and_check("sub3_10", 32'd3, 32'd10);
        op_and_check("ovf_neg", 32'h8000_0000, 32'h0000_0001);
        op_and_check("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        op_and_check("equal",   32'h1234_5678, 32'h1234_5678);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold", {difference[28:0], borrow, overflow, zero}, {e_diff[28:0], e_br, e_ov, e_z});
        end

        // A start pulse during RUN must not disturb the operation in flight.
        model(32'd100, 32'd1);
        start_op(32'd100, 32'd1);
        repeat (2) @(negedge clk);
        start = 1'b1; operand1 = 32'd5; operand2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        check_results("ignored_start");

        // Back-to-back: start raised while done is high.
        model(32'd7, 32'd9);
        start = 1'b1; operand1 = 32'd7; operand2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        wait_done(bc);
        check("b2b_latency", 32'(bc), 32'd8);
        check_results("b2b");

        // Reset during the 4th RUN cycle discards the operation.
        start_op(32'h0000_FFFF, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", difference, 32'd0);
        check("midrst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                2: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
                default: ;
            endcase
            op_and_check("rnd", a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
